// File: rtl/t_ff_pkg.sv
// Shared types for the T flip-flop bank: operating modes and counter width.
package t_ff_pkg;

   typedef enum logic [1:0] {
      TOGGLE     = 2'd0,
      COUNT_UP   = 2'd1,
      COUNT_DOWN = 2'd2,
      HOLD       = 2'd3
   } t_ff_mode_e;

   localparam int TOGGLE_CNT_W = 16;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop with synchronous active-low reset and parallel load.
module t_ff_cell (
   input  logic clk,
   input  logic reset,
   input  logic rst_val,
   input  logic load,
   input  logic load_val,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!reset)    q <= rst_val;
      else if (load) q <= load_val;
      else           q <= q ^ t;
   end

endmodule

// File: rtl/t_ff_bank.sv
// WIDTH-channel T-FF bank: independent toggles or up/down ripple-style counter.
// Optional 16-bit saturating toggle-event counter under T_FF_TOGGLE_CNT_EN.
module t_ff_bank
   import t_ff_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  t_ff_mode_e       mode,
   input  logic [WIDTH-1:0] t,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic [WIDTH-1:0] toggled
`ifdef T_FF_TOGGLE_CNT_EN
   ,
   output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);

   logic [WIDTH-1:0] w_t_up;
   logic [WIDTH-1:0] w_t_dn;
   logic [WIDTH-1:0] w_t_vec;
   logic [WIDTH-1:0] w_t_gate;
   logic [WIDTH-1:0] w_toggled_next;
   logic             w_all1;
   logic             w_all0;
   logic [WIDTH-1:0] r_toggled;

   // Running AND of lower bits: channel i toggles when everything below is saturated.
   always_comb begin
      w_all1 = 1'b1;
      w_all0 = 1'b1;
      w_t_up = '0;
      w_t_dn = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_t_up[i] = w_all1;
         w_t_dn[i] = w_all0;
         w_all1    = w_all1 & q[i];
         w_all0    = w_all0 & ~q[i];
      end
   end

   always_comb begin
      w_t_vec = '0;
      case (mode)
         TOGGLE:     w_t_vec = t;
         COUNT_UP:   w_t_vec = w_t_up;
         COUNT_DOWN: w_t_vec = w_t_dn;
         default:    w_t_vec = '0;
      endcase
   end

   assign w_t_gate       = en ? w_t_vec : '0;
   assign w_toggled_next = load ? (q ^ load_val) : w_t_gate;

   assign tc = en & (((mode == COUNT_UP)   & w_all1) |
                     ((mode == COUNT_DOWN) & w_all0));

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell u_cell (
         .clk      (clk),
         .reset    (reset),
         .rst_val  (RESET_VAL[i]),
         .load     (load),
         .load_val (load_val[i]),
         .t        (w_t_gate[i]),
         .q        (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) r_toggled <= '0;
      else        r_toggled <= w_toggled_next;
   end

   assign toggled = r_toggled;

`ifdef T_FF_TOGGLE_CNT_EN
   logic [TOGGLE_CNT_W-1:0] r_toggle_cnt;

   always_ff @(posedge clk) begin
      if (!reset)
         r_toggle_cnt <= '0;
      else if ((w_toggled_next != '0) && (r_toggle_cnt != {TOGGLE_CNT_W{1'b1}}))
         r_toggle_cnt <= r_toggle_cnt + 1'b1;
   end

   assign toggle_cnt = r_toggle_cnt;
`endif

endmodule

// File: doc/t_ff_bank.md
Name: t_ff_bank

Overview:
- Parametrised bank of WIDTH T flip-flops sharing one clock and one reset.
- Successor to the single-bit toggle flop used in our flop series.
- Two operating styles:
  - Independent per-channel toggling.
  - T-FF chain acting as a synchronous up or down counter.
- Adds load, enable, terminal count and a registered toggle-event vector.

Parameters:
- WIDTH, 4: number of T-FF channels (≥1).
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  global toggle enable.
- mode  in  2  t_ff_mode_e. Values: 0 TOGGLE, 1 COUNT_UP, 2 COUNT_DOWN, 3 HOLD.
- t  in  WIDTH  per-channel toggle requests; used in TOGGLE mode only.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- q  out  WIDTH  flop outputs.
- tc  out  1  terminal count; combinational.
- toggled  out  WIDTH  registered: bits of q that changed on the last edge.
- toggle_cnt  out  16  present only with T_FF_TOGGLE_CNT_EN.

Behaviour:
- Reset: all updates occur on posedge clk only.
  - reset==0 at an edge sets q=RESET_VAL and toggled=0 (toggle_cnt=0 when compiled in).
  - reset is not in any sensitivity list other than clk.
- Priority per edge: reset, then load, then en, then hold.
  - load=1: q <= load_val; toggled <= q ^ load_val; en, mode and t are ignored.
  - en=0 (no load): q holds; toggled <= 0.
- Per-channel toggle vector T, with q_next = q ^ T (en=1, no load):
  - TOGGLE: T = t.
  - COUNT_UP: T[0]=1; T[i] = &q[i-1:0]. Result is q+1 mod 2^WIDTH.
  - COUNT_DOWN: T[0]=1; T[i] = &~q[i-1:0]. Result is q-1 mod 2^WIDTH.
  - HOLD: T = 0.
- toggled <= T on enabled edges. It is valid the cycle after the edge.
- Latency: one clock from input to q. No multicycle paths.
- tc, combinational from the current q, mode and en:
  - COUNT_UP: en & (q == all-ones).
  - COUNT_DOWN: en & (q == 0).
  - TOGGLE and HOLD: 0.
- Wrap-around:
  - COUNT_UP at all-ones gives 0 next edge; COUNT_DOWN at 0 gives all-ones.
  - No saturation and no sticky flag.
- mode may change on any cycle; the new mode applies at the very next edge. There is no flush.
- reset deasserting mid-sequence: the first enabled edge after release operates on RESET_VAL.
- load and reset asserted together: reset wins.
- WIDTH=1: COUNT_UP and COUNT_DOWN both degenerate to a plain toggle.
- Neither q nor toggled is ever X after the first reset edge. No initial blocks in RTL.

Optional Feature:
- Macro: T_FF_TOGGLE_CNT_EN.
- Defined:
  - Adds 16-bit output toggle_cnt, counting edges on which toggled_next != 0 (any channel changed, load included).
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package t_ff_pkg:
  - typedef enum logic [1:0] t_ff_mode_e {TOGGLE, COUNT_UP, COUNT_DOWN, HOLD}.
  - localparam TOGGLE_CNT_W = 16.
- Sub-module t_ff_cell: one T flip-flop.
  - Inputs: clk, reset (sync active-low), rst_val, load, load_val, t.
  - Output: q.
  - Instantiated WIDTH times via generate.
- Top-level owns T-vector generation, tc, toggled and the optional counter.

Test Plan:
- Reset and TOGGLE (WIDTH=4, RESET_VAL=4'b0001):
  - Hold reset=0 for 2 edges → q=0001, toggled=0.
  - Release, en=1, mode=TOGGLE, t=1010 → q=1011, toggled=1010.
  - Next edge → q=0001.
- COUNT_UP wrap: load_val=1110, load=1, then mode=COUNT_UP, en=1.
  - q sequence: 1110 → 1111 (tc=1) → 0000 (tc=0).
  - toggled=1111 after the wrap edge.
- COUNT_DOWN wrap: load 0001, mode=COUNT_DOWN.
  - q sequence: 0001 → 0000 (tc=1) → 1111.
  - en=0 at q=0000 → tc=0, q holds.
- Priority: reset=0 with load=1, load_val=0110 → q=RESET_VAL.
  - Next edge, reset=1, load=1 → q=0110 regardless of mode=COUNT_UP and en=1.
- Mid-count mode switch: q=0101 counting up.
  - Switch to COUNT_DOWN for one edge → q=0100 (not 0110).
  - Switch to HOLD → q stays 0100, toggled=0.
- With T_FF_TOGGLE_CNT_EN: 20 enabled COUNT_UP edges → toggle_cnt=20.
  - Preset an internal count near saturation via force; 5 more edges → 16'hFFFF held.
  - reset=0 → toggle_cnt=0.
